// File: rtl/exhaustive_response_checker_if.sv
// Bundle of the checker's sweep, result and status signals.
// The master modport is the checker itself. The slave modport is whatever
// drives start, dut_resp and res_ready, and consumes the results.
interface exhaustive_response_checker_if #(
    parameter int N_IN = 2
);
    logic                     start;
    logic [N_IN-1:0]          pat_out;
    logic                     pat_valid;
    logic                     dut_resp;
    logic                     res_valid;
    logic                     res_ready;
    logic [N_IN-1:0]          res_pattern;
    logic                     res_bit;
    logic                     res_err;
    logic                     busy;
    logic                     done;
    logic [N_IN:0]            mismatch_cnt;
    logic [(1<<N_IN)-1:0]     mismatch_map;
    logic                     trojan_flag;

    modport master (
        input  start, dut_resp, res_ready,
        output pat_out, pat_valid, res_valid, res_pattern, res_bit, res_err,
               busy, done, mismatch_cnt, mismatch_map, trojan_flag
    );

    modport slave (
        output start, dut_resp, res_ready,
        input  pat_out, pat_valid, res_valid, res_pattern, res_bit, res_err,
               busy, done, mismatch_cnt, mismatch_map, trojan_flag
    );
endinterface

// File: rtl/exhaustive_response_checker.sv
// Exhaustive response checker.
// Each sweep applies every input pattern of a small DUT in ascending order and
// waits SETTLE cycles before sampling the single-bit response. Each sample is
// compared against the GOLDEN truth table. The result for each pattern is
// streamed out over a valid/ready port. At the end of the sweep the block
// reports a mismatch count, a per-pattern mismatch map and trojan_flag.
module exhaustive_response_checker #(
    parameter int                   N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0] GOLDEN = 4'b0110,
    parameter int                   SETTLE = 1
) (
    input  logic                           CK,
    input  logic                           reset,
    exhaustive_response_checker_if.master  bus
);
    localparam int              N_PAT       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_PAT    = N_IN'(N_PAT - 1);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [N_IN-1:0] pattern_reg, pattern_next;
    logic [3:0]      settle_reg, settle_next;
    logic [N_IN-1:0] res_pattern_reg, res_pattern_next;
    logic            res_bit_reg, res_bit_next;
    logic            res_err_reg, res_err_next;
    logic [N_IN:0]   cnt_reg, cnt_next;
    logic [N_PAT-1:0] map_reg, map_next;

    logic sweep_start;
    logic sample_err;

    // start is honoured only from IDLE or DONE; a start during a sweep is ignored
    assign sweep_start = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && bus.start;
    assign sample_err  = bus.dut_resp ^ GOLDEN[pattern_reg];

    // Next-state and datapath updates for the sweep sequencer
    always_comb begin
        state_next       = state_reg;
        pattern_next     = pattern_reg;
        settle_next      = settle_reg;
        res_pattern_next = res_pattern_reg;
        res_bit_next     = res_bit_reg;
        res_err_next     = res_err_reg;
        cnt_next         = cnt_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_next   = S_APPLY;
                    pattern_next = '0;
                    cnt_next     = '0;
                end
            end
            S_APPLY: begin
                settle_next = SETTLE_LOAD;
                state_next  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_reg == 4'd0) begin
                    state_next = S_SAMPLE;
                end else begin
                    settle_next = settle_reg - 4'd1;
                end
            end
            S_SAMPLE: begin
                res_pattern_next = pattern_reg;
                res_bit_next     = bus.dut_resp;
                res_err_next     = sample_err;
                if (sample_err) begin
                    cnt_next = cnt_reg + (N_IN+1)'(1);
                end
                state_next = S_REPORT;
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    if (pattern_reg == LAST_PAT) begin
                        state_next = S_DONE;
                    end else begin
                        pattern_next = pattern_reg + N_IN'(1);
                        state_next   = S_APPLY;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Each mismatch-map bit is set by a mismatching sample of its own pattern and cleared by a new sweep
    genvar gi;
    generate
        for (gi = 0; gi < N_PAT; gi++) begin : g_map
            assign map_next[gi] = sweep_start ? 1'b0 :
                (map_reg[gi] | ((state_reg == S_SAMPLE) && sample_err &&
                                (pattern_reg == N_IN'(gi))));
        end
    endgenerate

    // State and datapath registers; reset aborts any sweep and clears everything
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            pattern_reg     <= '0;
            settle_reg      <= '0;
            res_pattern_reg <= '0;
            res_bit_reg     <= 1'b0;
            res_err_reg     <= 1'b0;
            cnt_reg         <= '0;
            map_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            pattern_reg     <= pattern_next;
            settle_reg      <= settle_next;
            res_pattern_reg <= res_pattern_next;
            res_bit_reg     <= res_bit_next;
            res_err_reg     <= res_err_next;
            cnt_reg         <= cnt_next;
            map_reg         <= map_next;
        end
    end

    // pat_out tracks the live pattern and keeps the last one after the sweep ends
    assign bus.pat_out      = pattern_reg;
    assign bus.busy         = (state_reg == S_APPLY) || (state_reg == S_SETTLE) ||
                              (state_reg == S_SAMPLE) || (state_reg == S_REPORT);
    assign bus.pat_valid    = bus.busy;
    assign bus.res_valid    = (state_reg == S_REPORT);
    assign bus.res_pattern  = res_pattern_reg;
    assign bus.res_bit      = res_bit_reg;
    assign bus.res_err      = res_err_reg;
    assign bus.done         = (state_reg == S_DONE);
    assign bus.mismatch_cnt = cnt_reg;
    assign bus.mismatch_map = map_reg;
    assign bus.trojan_flag  = (cnt_reg != '0);
endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Bench for exhaustive_response_checker.
// It uses two instances, one with SETTLE=1 and one with SETTLE=3. Each sweep
// is set against a truth-table model of the DUT, and one line is printed per
// result.
module tb_exhaustive_response_checker;
    localparam int         N_IN   = 2;
    localparam logic [3:0] GOLDEN = 4'b0110;

    typedef struct {
        int         id;
        int         sel;
        logic [3:0] tt;
        int         stall_pat;
        int         stall_len;
        int         extra_start_n;
        int         exp_cnt;
        logic [3:0] exp_map;
        int         exp_cycles;
    } vec_t;

    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       res_ready = 1'b1;
    int         sel = 0;
    logic [3:0] tt = 4'b0110;

    int checks = 0;
    int failures = 0;

    always #5 ck = ~ck;

    exhaustive_response_checker_if #(.N_IN(N_IN)) bus1 ();
    exhaustive_response_checker_if #(.N_IN(N_IN)) bus3 ();

    exhaustive_response_checker #(.N_IN(N_IN), .GOLDEN(GOLDEN), .SETTLE(1)) dut1 (
        .CK(ck), .reset(rst_n), .bus(bus1.master)
    );
    exhaustive_response_checker #(.N_IN(N_IN), .GOLDEN(GOLDEN), .SETTLE(3)) dut3 (
        .CK(ck), .reset(rst_n), .bus(bus3.master)
    );

    // The truth table tt models the DUT under test.
    assign bus1.start     = (sel == 0) ? start : 1'b0;
    assign bus3.start     = (sel == 1) ? start : 1'b0;
    assign bus1.res_ready = res_ready;
    assign bus3.res_ready = res_ready;
    assign bus1.dut_resp  = tt[bus1.pat_out];
    assign bus3.dut_resp  = tt[bus3.pat_out];

    logic [1:0] s_pat_out, s_res_pattern;
    logic       s_pat_valid, s_res_valid, s_res_bit, s_res_err, s_busy, s_done, s_trojan;
    logic [2:0] s_cnt;
    logic [3:0] s_map;
    assign s_pat_out     = (sel == 0) ? bus1.pat_out      : bus3.pat_out;
    assign s_pat_valid   = (sel == 0) ? bus1.pat_valid    : bus3.pat_valid;
    assign s_res_valid   = (sel == 0) ? bus1.res_valid    : bus3.res_valid;
    assign s_res_pattern = (sel == 0) ? bus1.res_pattern  : bus3.res_pattern;
    assign s_res_bit     = (sel == 0) ? bus1.res_bit      : bus3.res_bit;
    assign s_res_err     = (sel == 0) ? bus1.res_err      : bus3.res_err;
    assign s_busy        = (sel == 0) ? bus1.busy         : bus3.busy;
    assign s_done        = (sel == 0) ? bus1.done         : bus3.done;
    assign s_cnt         = (sel == 0) ? bus1.mismatch_cnt : bus3.mismatch_cnt;
    assign s_map         = (sel == 0) ? bus1.mismatch_map : bus3.mismatch_map;
    assign s_trojan      = (sel == 0) ? bus1.trojan_flag  : bus3.trojan_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the expected sweep outcome, derived directly from the truth tables.
    function automatic void model_sweep(input logic [3:0] t, input int settle, input int stall,
                                        output int cnt, output logic [3:0] map, output int cycles);
        logic [3:0] g;
        g = GOLDEN;
        cnt = 0;
        map = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (t[k] != g[k]) begin
                map[k] = 1'b1;
                cnt++;
            end
        end
        cycles = 4 * (settle + 3) + stall;
    endfunction

    function automatic logic [31:0] out_vec();
        return 32'({s_pat_out, s_pat_valid, s_res_valid, s_res_pattern, s_res_bit, s_res_err,
                    s_busy, s_done, s_cnt, s_map, s_trojan});
    endfunction

    task automatic run_sweep(input vec_t v);
        int         n;
        int         idx;
        int         stalled;
        bit         got_done;
        logic [3:0] g;
        g = GOLDEN;
        sel = v.sel;
        tt = v.tt;
        res_ready = 1'b1;
        @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        n = 0;
        idx = 0;
        stalled = 0;
        got_done = 0;
        check($sformatf("v%0d_busy_after_start", v.id), 32'(s_busy), 1);
        check($sformatf("v%0d_done_cleared", v.id), 32'(s_done), 0);
        check($sformatf("v%0d_cnt_cleared", v.id), 32'(s_cnt), 0);
        while (!got_done && n < 400) begin
            if (s_done) begin
                got_done = 1;
                start = 1'b0;
            end else begin
                start = (n == v.extra_start_n);
                if (s_res_valid) begin
                    if (idx == v.stall_pat && stalled < v.stall_len) begin
                        res_ready = 1'b0;
                        stalled++;
                        check($sformatf("v%0d_stall_res_pattern", v.id), 32'(s_res_pattern), 32'(idx));
                        check($sformatf("v%0d_stall_pat_out", v.id), 32'(s_pat_out), 32'(idx));
                    end else begin
                        res_ready = 1'b1;
                        $display("result v%0d pattern=%0d bit=%0d err=%0d", v.id, s_res_pattern, s_res_bit, s_res_err);
                        check($sformatf("v%0d_res_pattern", v.id), 32'(s_res_pattern), 32'(idx));
                        check($sformatf("v%0d_res_bit", v.id), 32'(s_res_bit), 32'(tt[idx]));
                        check($sformatf("v%0d_res_err", v.id), 32'(s_res_err), 32'(tt[idx] ^ g[idx]));
                        idx++;
                    end
                end else begin
                    res_ready = 1'($urandom_range(0, 1));
                end
                @(negedge ck);
                n++;
            end
        end
        res_ready = 1'b1;
        check($sformatf("v%0d_done_reached", v.id), 32'(got_done), 1);
        check($sformatf("v%0d_done_cycles", v.id), 32'(n), 32'(v.exp_cycles));
        check($sformatf("v%0d_result_count", v.id), 32'(idx), 4);
        check($sformatf("v%0d_mismatch_cnt", v.id), 32'(s_cnt), 32'(v.exp_cnt));
        check($sformatf("v%0d_mismatch_map", v.id), 32'(s_map), 32'(v.exp_map));
        check($sformatf("v%0d_trojan_flag", v.id), 32'(s_trojan), 32'(v.exp_cnt != 0));
        check($sformatf("v%0d_pat_out_last", v.id), 32'(s_pat_out), 3);
        check($sformatf("v%0d_idle_flags", v.id), 32'({s_busy, s_pat_valid, s_res_valid}), 0);
        repeat (2) @(negedge ck);
        check($sformatf("v%0d_done_held", v.id), 32'({s_done, s_busy}), 32'(2'b10));
        check($sformatf("v%0d_map_held", v.id), 32'(s_map), 32'(v.exp_map));
        $display("sweep v%0d sel=%0d tt=%b cycles=%0d cnt=%0d map=%b", v.id, v.sel, v.tt, n, s_cnt, s_map);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t rv;
        vecs[0] = '{0, 0, 4'b0110, -1, 0, -1, 0, 4'b0000, 16};
        vecs[1] = '{1, 0, 4'b1110, -1, 0, -1, 1, 4'b1000, 16};
        vecs[2] = '{2, 0, 4'b0110,  1, 5, -1, 0, 4'b0000, 21};
        vecs[3] = '{3, 0, 4'b0110, -1, 0,  5, 0, 4'b0000, 16};
        vecs[4] = '{4, 0, 4'b1110, -1, 0, 15, 1, 4'b1000, 16};
        vecs[5] = '{5, 1, 4'b1001, -1, 0, -1, 4, 4'b1111, 24};
        vecs[6] = '{6, 1, 4'b0010,  3, 2, -1, 1, 4'b0100, 26};

        // Everything reads as zero while reset is held, on both instances.
        repeat (3) @(negedge ck);
        sel = 0;
        check("reset_outputs_s1", out_vec(), 0);
        sel = 1;
        check("reset_outputs_s3", out_vec(), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge ck);
        check("idle_after_reset", 32'({s_busy, s_done}), 0);

        for (int i = 0; i < 7; i++) begin
            run_sweep(vecs[i]);
        end

        // Reset during SETTLE of pattern 2 aborts the sweep asynchronously.
        sel = 0;
        tt = 4'b1001;
        res_ready = 1'b1;
        @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        repeat (9) @(negedge ck);
        check("midsweep_pat_out", 32'({s_pat_out, s_pat_valid, s_res_valid}), 32'(4'b1010));
        check("midsweep_cnt", 32'(s_cnt), 2);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_vec(), 0);
        @(negedge ck);
        rst_n = 1'b1;
        repeat (5) @(negedge ck);
        check("stays_idle_after_abort", 32'({s_busy, s_pat_valid, s_done, s_res_valid}), 0);
        rv = vecs[0];
        rv.id = 7;
        run_sweep(rv);

        // Randomized sweeps checked against the reference model.
        for (int i = 0; i < 10; i++) begin
            rv.id = 8 + i;
            rv.sel = int'($urandom_range(0, 1));
            rv.tt = 4'($urandom);
            rv.stall_pat = int'($urandom_range(0, 3));
            rv.stall_len = int'($urandom_range(0, 4));
            model_sweep(rv.tt, (rv.sel == 0) ? 1 : 3, rv.stall_len, rv.exp_cnt, rv.exp_map, rv.exp_cycles);
            rv.extra_start_n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rv.exp_cycles - 1)) : -1;
            run_sweep(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exhaustive_response_checker.md
Name: exhaustive_response_checker

Overview:
- Hardware counterpart of the team's exhaustive-vector benches.
- Drives every input pattern of a small test_* DUT in ascending order, waits a settle window, and samples the DUT's single-bit response.
- Compares each sample against a golden truth table and streams per-pattern results out over a valid/ready port.
- Raises trojan_flag at the end of a sweep if any pattern mismatched.
- Sits between the DUT-under-test and the on-chip result logger.

Parameters:
- N_IN, 2, number of DUT input bits; the sweep covers 2**N_IN patterns.
- GOLDEN, 4'b0110, golden response table, width 2**N_IN; bit k is the expected response to pattern k.
- SETTLE, 1, cycles to wait after applying a pattern before sampling; legal range 1..15.

Ports:
- CK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse that begins a sweep; sampled only in IDLE or DONE.
- pat_out  output  N_IN  pattern driven to the DUT inputs.
- pat_valid  output  1  high while pat_out carries a live pattern.
- dut_resp  input  1  DUT response bit.
- res_valid  output  1  per-pattern result available.
- res_ready  input  1  consumer accepts the result.
- res_pattern  output  N_IN  pattern the result refers to.
- res_bit  output  1  sampled dut_resp.
- res_err  output  1  res_bit differs from GOLDEN[res_pattern].
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start.
- mismatch_cnt  output  N_IN+1  number of mismatching patterns in the sweep.
- mismatch_map  output  2**N_IN  bit k set if pattern k mismatched.
- trojan_flag  output  1  equals (mismatch_cnt != 0); valid while done=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pattern=0, settle counter=0.
- All outputs are 0 in reset, including pat_out, pat_valid, res_*, busy, done, mismatch_cnt, mismatch_map and trojan_flag.
- Reset asserted mid-sweep aborts immediately with no partial result; the next sweep needs a fresh start.
- FSM states are IDLE, APPLY, SETTLE, SAMPLE, REPORT, DONE.
- IDLE/DONE → APPLY on start=1:
  - pattern=0.
  - mismatch_cnt, mismatch_map and done are cleared on that edge.
  - busy=1.
- APPLY, 1 cycle:
  - pat_out=pattern, pat_valid=1.
  - Settle counter loads SETTLE-1; go to SETTLE.
- SETTLE, SETTLE cycles: counter decrements; go to SAMPLE when the counter is 0.
- SAMPLE, 1 cycle:
  - res_bit=dut_resp, res_pattern=pattern, res_err=dut_resp^GOLDEN[pattern].
  - On a mismatch, set mismatch_map[pattern] and increment mismatch_cnt.
  - res_valid=1; go to REPORT.
- REPORT:
  - res_valid, res_* and pat_out hold stable until res_ready=1. A stall is unbounded and changes nothing.
  - On handshake (res_valid & res_ready): res_valid drops on the next edge.
  - If pattern==2**N_IN-1, go to DONE. Otherwise pattern+1 and go to APPLY.
- DONE:
  - busy=0, done=1, pat_valid=0.
  - pat_out holds the last pattern.
  - mismatch_cnt, mismatch_map and trojan_flag hold until the next start.
- Per-pattern latency with res_ready tied high is SETTLE+3 cycles; a full sweep takes 2**N_IN*(SETTLE+3) cycles from the start edge to done.
- start while busy=1 is ignored.
- start asserted on the same edge DONE is entered is ignored; it takes effect from DONE on the following cycle.
- pattern never wraps; the sweep terminates after the last pattern.
- mismatch_cnt cannot overflow, since its maximum value 2**N_IN fits in N_IN+1 bits.
- res_ready is ignored outside REPORT.
- dut_resp is sampled only in SAMPLE.
- pat_out is stable from APPLY through the REPORT handshake.

Test Plan:
- Clean sweep: defaults, DUT model is XOR of the inputs, res_ready=1, start pulse → results stream with patterns 0,1,2,3 and bits 0,1,1,0, all res_err=0. Then done=1 at start+16 cycles, mismatch_cnt=0, trojan_flag=0.
- Trojan on pattern 3: DUT outputs 1 for 2'b11 → res_err=1 only for pattern 3, mismatch_map=4'b1000, mismatch_cnt=1, trojan_flag=1.
- Backpressure: res_ready held low for 5 cycles in the pattern-1 REPORT → res_valid and res_pattern=1 stay stable and pat_out stays 2'b01 throughout. The sweep then completes with total duration +5 cycles.
- Reset mid-sweep: reset=0 during SETTLE of pattern 2 → all outputs 0 asynchronously. After release with no start, the block stays in IDLE; a new start sweeps from pattern 0.
- Start while busy: second start pulse during pattern 1 → ignored, and exactly 4 results are emitted.
- All-wrong DUT (inverted XOR) with SETTLE=3 → mismatch_cnt=4 (3'b100), mismatch_map=4'b1111, done at start+24 cycles.
